// File: rtl/bridge_dataslot_finder_if.sv
// Word-wide read/write bus between the dataslot finder (initiator) and the
// bridge memory that holds the dataslot table.
interface bus_if;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_data_valid;

  modport master (
    output addr, rd, wr, wr_data,
    input  rd_data, rd_data_valid
  );

  modport slave (
    input  addr, rd, wr, wr_data,
    output rd_data, rd_data_valid
  );
endinterface

// File: rtl/bridge_dataslot_finder.sv
// Walks the bridge dataslot table looking for an entry whose id matches
// slot_id, then fetches that entry's size word. Each read has a timeout.
module bridge_dataslot_finder #(
  parameter logic [31:0] TABLE_BASE = 32'hF800_2000,
  parameter int          MAX_SLOTS  = 32,
  parameter int          TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] slot_id,
  bus_if.master       bridge_dataslot,
  output logic        busy,
  output logic        done,
  output logic        slot_base_found,
  output logic [31:0] slot_base_address,
  output logic [31:0] slot_size,
  output logic        timeout_err
);

  localparam int IDX_W = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_SIZE,
    WAIT_SIZE,
    FINISH
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   tmo_q;
  logic [15:0]        id_q;
  logic               rd_q;
  logic [31:0]        addr_q;
  logic               busy_q;
  logic               done_q;
  logic               found_q;
  logic [31:0]        base_q;
  logic [31:0]        size_q;
  logic               to_q;

  logic [IDX_W-1:0]   idx_d;
  logic [31:0]        entry_addr_d;
  logic [31:0]        next_entry_addr_d;
  logic               last_entry;
  logic               tmo_hit;

  // All address arithmetic is plain 32-bit unsigned, so it wraps naturally.
  assign idx_d             = idx_q + IDX_W'(1);
  assign entry_addr_d      = TABLE_BASE + (32'(idx_q) << 3);
  assign next_entry_addr_d = TABLE_BASE + (32'(idx_d) << 3);
  assign last_entry        = (idx_q == IDX_W'(MAX_SLOTS - 1));
  assign tmo_hit           = (tmo_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      id_q    <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      base_q  <= '0;
      size_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        // rd is raised on the transition into a read state, so it is high
        // exactly while the FSM sits in RD_ID / RD_SIZE.
        IDLE: begin
          if (start) begin
            id_q    <= slot_id;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            found_q <= 1'b0;
            to_q    <= 1'b0;
            base_q  <= '0;
            size_q  <= '0;
            rd_q    <= 1'b1;
            addr_q  <= TABLE_BASE;
            state_q <= RD_ID;
          end
        end
        RD_ID: begin
          tmo_q   <= '0;
          state_q <= WAIT_ID;
        end
        WAIT_ID: begin
          if (bridge_dataslot.rd_data_valid) begin
            if (bridge_dataslot.rd_data[15:0] == id_q) begin
              rd_q    <= 1'b1;
              addr_q  <= entry_addr_d + 32'd4;
              state_q <= RD_SIZE;
            end else if (last_entry) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FINISH;
            end else begin
              idx_q   <= idx_d;
              rd_q    <= 1'b1;
              addr_q  <= next_entry_addr_d;
              state_q <= RD_ID;
            end
          end else if (tmo_hit) begin
            to_q    <= 1'b1;
            found_q <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
        end
        RD_SIZE: begin
          tmo_q   <= '0;
          state_q <= WAIT_SIZE;
        end
        WAIT_SIZE: begin
          if (bridge_dataslot.rd_data_valid) begin
            size_q  <= bridge_dataslot.rd_data;
            base_q  <= entry_addr_d;
            found_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else if (tmo_hit) begin
            to_q    <= 1'b1;
            found_q <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bridge_dataslot.addr    = addr_q;
  assign bridge_dataslot.rd      = rd_q;
  assign bridge_dataslot.wr      = 1'b0;
  assign bridge_dataslot.wr_data = 32'd0;

  assign busy              = busy_q;
  assign done              = done_q;
  assign slot_base_found   = found_q;
  assign slot_base_address = base_q;
  assign slot_size         = size_q;
  assign timeout_err       = to_q;

endmodule

// File: tb/tb_bridge_dataslot_finder.sv
// Directed bench for bridge_dataslot_finder: a table-driven set of searches
// against a modelled dataslot table, plus busy-start and mid-search reset cases.
module tb_bridge_dataslot_finder;

  localparam logic [31:0] BASE = 32'hF800_2000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] slot_id;
  logic        busy, done, found, to_err;
  logic [31:0] base_addr, size;

  bus_if bus ();

  bridge_dataslot_finder #(
    .TABLE_BASE (BASE),
    .MAX_SLOTS  (32),
    .TIMEOUT    (255)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .slot_id           (slot_id),
    .bridge_dataslot   (bus),
    .busy              (busy),
    .done              (done),
    .slot_base_found   (found),
    .slot_base_address (base_addr),
    .slot_size         (size),
    .timeout_err       (to_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // table contents and responder configuration (written only by the test process)
  logic [15:0] tbl_id   [32];
  logic [31:0] tbl_size [32];
  int          lat_cfg    = 1;
  bit          silent_cfg = 1'b0;
  bit          zl_cfg     = 1'b0;
  logic [15:0] zl_id      = 16'h0;

  // monitor / responder state (written only by the monitor)
  int          nreads = 0, ndone = 0, rd_dbl = 0, wr_bad = 0;
  int          wait_entry_cyc = 0, done_cyc = 0;
  logic [31:0] last_rd_addr = 32'h0;
  bit          prev_rd = 1'b0, pend = 1'b0;
  int          pcnt = 0;
  logic [31:0] paddr = 32'h0;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] off;
    int          i;
    off = a - BASE;
    if (off >= 32'd256) return 32'hDEAD_0000;
    i = int'(off >> 3);
    return a[2] ? tbl_size[i] : {16'hBEEF, tbl_id[i]};
  endfunction

  always @(negedge clk) begin
    bus.rd_data_valid = 1'b0;
    if (pend) begin
      if (pcnt <= 1) begin
        bus.rd_data_valid = 1'b1;
        bus.rd_data       = mem_rd(paddr);
        pend              = 1'b0;
      end else begin
        pcnt = pcnt - 1;
      end
    end
    if (bus.rd === 1'b1) begin
      nreads       = nreads + 1;
      last_rd_addr = bus.addr;
      if (prev_rd) rd_dbl = rd_dbl + 1;
      if (zl_cfg) begin
        bus.rd_data_valid = 1'b1;
        bus.rd_data       = {16'h0000, zl_id};
      end
      if (!silent_cfg) begin
        pend  = 1'b1;
        pcnt  = (lat_cfg == 0) ? int'($urandom_range(10, 1)) : lat_cfg;
        paddr = bus.addr;
      end
    end
    if (prev_rd && bus.rd !== 1'b1) wait_entry_cyc = cyc;
    prev_rd = (bus.rd === 1'b1);
    if (bus.wr !== 1'b0 || bus.wr_data !== 32'd0) wr_bad = wr_bad + 1;
    if (done === 1'b1) begin
      ndone    = ndone + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int d0, input string name);
    int t;
    t = 0;
    while (ndone == d0 && t < 3000) begin
      @(negedge clk); #1;
      t = t + 1;
    end
    if (ndone == d0) check({name, "_done_seen"}, 32'(ndone - d0), 32'd1);
  endtask

  typedef struct {
    logic [15:0] slot;
    int          lat;
    bit          silent;
    bit          zl;
    logic        found;
    logic [31:0] base;
    logic [31:0] size;
    logic        to;
    int          nrd;
    logic [31:0] last;
    int          exp_lat;
    int          exp_tmo;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input int k, input vec_t v);
    int    n0, d0, s_cyc;
    string nm;
    nm = $sformatf("vec%0d", k);
    lat_cfg = v.lat; silent_cfg = v.silent; zl_cfg = v.zl; zl_id = v.slot;
    n0 = nreads; d0 = ndone;
    @(negedge clk); #1;
    start = 1'b1; slot_id = v.slot; s_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(d0, nm);
    repeat (4) @(negedge clk);
    #1;
    check({nm, "_done_pulses"}, 32'(ndone - d0), 32'd1);
    check({nm, "_found"}, {31'd0, found}, {31'd0, v.found});
    check({nm, "_base"}, base_addr, v.base);
    check({nm, "_size"}, size, v.size);
    check({nm, "_timeout_err"}, {31'd0, to_err}, {31'd0, v.to});
    check({nm, "_nreads"}, 32'(nreads - n0), 32'(v.nrd));
    check({nm, "_last_addr"}, last_rd_addr, v.last);
    check({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
    if (v.exp_lat != 0) check({nm, "_latency"}, 32'(done_cyc - s_cyc + 1), 32'(v.exp_lat));
    if (v.exp_tmo != 0) check({nm, "_timeout_cycles"}, 32'(done_cyc - wait_entry_cyc), 32'(v.exp_tmo));
  endtask

  initial begin
    int n0, d0, t;
    for (int i = 0; i < 32; i++) begin
      tbl_id[i]   = 16'h0100 + 16'(i);
      tbl_size[i] = 32'h1000_0000 + 32'(i);
    end
    tbl_id[2]    = 16'h0003;
    tbl_size[2]  = 32'h0001_2345;
    tbl_id[31]   = 16'h0777;
    tbl_size[31] = 32'hCAFE_0031;

    //        slot    lat sil zl found base          size          to nrd last          lat tmo
    vecs[0] = '{16'h0003, 1, 0, 0, 1'b1, 32'hF800_2010, 32'h0001_2345, 1'b0, 4,  32'hF800_2014, 0, 0};
    vecs[1] = '{16'h00FF, 1, 0, 0, 1'b0, 32'h0,         32'h0,         1'b0, 32, 32'hF800_20F8, 0, 0};
    vecs[2] = '{16'h0100, 1, 0, 0, 1'b1, 32'hF800_2000, 32'h1000_0000, 1'b0, 2,  32'hF800_2004, 6, 0};
    vecs[3] = '{16'h0777, 0, 0, 0, 1'b1, 32'hF800_20F8, 32'hCAFE_0031, 1'b0, 33, 32'hF800_20FC, 0, 0};
    vecs[4] = '{16'h0105, 3, 0, 0, 1'b1, 32'hF800_2028, 32'h1000_0005, 1'b0, 7,  32'hF800_202C, 0, 0};
    vecs[5] = '{16'h0003, 1, 1, 0, 1'b0, 32'h0,         32'h0,         1'b1, 1,  32'hF800_2000, 0, 255};
    vecs[6] = '{16'h0003, 1, 0, 1, 1'b1, 32'hF800_2010, 32'h0001_2345, 1'b0, 4,  32'hF800_2014, 0, 0};

    reset_n = 1'b0; start = 1'b0; slot_id = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy",  {31'd0, busy},   32'd0);
    check("reset_done",  {31'd0, done},   32'd0);
    check("reset_found", {31'd0, found},  32'd0);
    check("reset_to",    {31'd0, to_err}, 32'd0);
    check("reset_base",  base_addr, 32'd0);
    check("reset_size",  size,      32'd0);
    check("reset_rd",    {31'd0, bus.rd}, 32'd0);
    check("reset_addr",  bus.addr,  32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // second start while busy must be ignored
    lat_cfg = 1; silent_cfg = 1'b0; zl_cfg = 1'b0;
    n0 = nreads; d0 = ndone;
    @(negedge clk); #1;
    start = 1'b1; slot_id = 16'h0003;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    start = 1'b1; slot_id = 16'h0100;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(d0, "busy_start");
    repeat (6) @(negedge clk);
    #1;
    check("busy_start_done_pulses", 32'(ndone - d0), 32'd1);
    check("busy_start_found", {31'd0, found}, 32'd1);
    check("busy_start_base", base_addr, 32'hF800_2010);
    check("busy_start_size", size, 32'h0001_2345);
    check("busy_start_nreads", 32'(nreads - n0), 32'd4);

    // reset during WAIT_SIZE, response arrives after reset
    lat_cfg = 5;
    n0 = nreads; d0 = ndone;
    @(negedge clk); #1;
    start = 1'b1; slot_id = 16'h0003;
    @(negedge clk); #1;
    start = 1'b0;
    t = 0;
    while ((nreads - n0) < 4 && t < 500) begin
      @(negedge clk); #1;
      t = t + 1;
    end
    check("rst_mid_size_read_seen", 32'(nreads - n0), 32'd4);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n0 = nreads;
    repeat (20) @(negedge clk);
    #1;
    check("rst_mid_no_done", 32'(ndone - d0), 32'd0);
    check("rst_mid_busy",  {31'd0, busy},   32'd0);
    check("rst_mid_found", {31'd0, found},  32'd0);
    check("rst_mid_to",    {31'd0, to_err}, 32'd0);
    check("rst_mid_base",  base_addr, 32'd0);
    check("rst_mid_size",  size,      32'd0);
    check("rst_mid_addr",  bus.addr,  32'd0);
    check("rst_mid_rd",    {31'd0, bus.rd}, 32'd0);
    check("rst_mid_no_reads", 32'(nreads - n0), 32'd0);

    check("rd_single_cycle", 32'(rd_dbl), 32'd0);
    check("wr_always_zero",  32'(wr_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bridge_dataslot_finder.md
BRIDGE_DATASLOT_FINDER -- requirements
Module: bridge_dataslot_finder

Interface
REQ-001 Parameters SHALL be: TABLE_BASE, 32'hF800_2000, byte address of dataslot entry 0; MAX_SLOTS, 32, number of 8-byte entries searched; TIMEOUT, 255, cycles allowed per read before abort.
REQ-002 Ports SHALL be: clk  in  1  single clock; all logic is on its rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 start  in  1  one-cycle pulse that begins a search.
REQ-005 slot_id  in  16  dataslot id to locate; sampled on the accepted start.
REQ-006 bridge_dataslot  bus_if  -  initiator side: drives addr, rd, wr, wr_data; samples rd_data and rd_data_valid.
REQ-007 busy  out  1  search in progress.
REQ-008 done  out  1  one-cycle pulse at search end.
REQ-009 slot_base_found  out  1  last search matched.
REQ-010 slot_base_address  out  32  byte address of the matched entry's even word.
REQ-011 slot_size  out  32  odd word of the matched entry.
REQ-012 timeout_err  out  1  last search aborted on read timeout.

Function
REQ-013 The block SHALL read the entry at TABLE_BASE+8*i with two word reads: even word at offset 0, where id is bits [15:0]; odd word at offset 4, which holds the size.
REQ-014 The FSM states SHALL be IDLE, RD_ID, WAIT_ID, RD_SIZE, WAIT_SIZE and FINISH.
REQ-015 IDLE -> RD_ID on start: latch slot_id, set index i=0, set busy=1, and clear slot_base_found, timeout_err, slot_base_address and slot_size.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 RD_ID SHALL assert rd for exactly one cycle with addr=TABLE_BASE+8*i, then go to WAIT_ID.
REQ-018 WAIT_ID on rd_data_valid:
- if rd_data[15:0]==latched id -> RD_SIZE;
- else if i==MAX_SLOTS-1 -> FINISH, not found;
- else increment i -> RD_ID.
REQ-019 RD_SIZE SHALL assert rd for exactly one cycle with addr=TABLE_BASE+8*i+4, then go to WAIT_SIZE.
REQ-020 WAIT_SIZE on rd_data_valid SHALL capture slot_size=rd_data, slot_base_address=TABLE_BASE+8*i and slot_base_found=1, then go to FINISH.
REQ-021 In the WAIT states, a per-read cycle counter SHALL be cleared on entry and incremented each cycle without rd_data_valid. When it reaches TIMEOUT the FSM SHALL go to FINISH with timeout_err=1 and slot_base_found=0.
REQ-022 rd_data_valid outside the WAIT states SHALL be ignored.
REQ-023 rd_data_valid in the same cycle as rd (zero latency) SHALL NOT be accepted; data is accepted only while in a WAIT state.
REQ-024 FINISH SHALL pulse done=1 for one cycle, drop busy, and return to IDLE.
REQ-025 Result outputs SHALL hold their values until the next accepted start.
REQ-026 wr and wr_data SHALL be driven 0 at all times; addr SHALL hold its last value between reads.
REQ-027 Address arithmetic SHALL be 32-bit unsigned and wrap modulo 2^32.
REQ-028 The index counter SHALL be wide enough for MAX_SLOTS-1 and SHALL NOT wrap during a search.
REQ-029 Minimum latency from start to done SHALL be 6 cycles: a match on entry 0 with read data valid the cycle after rd.

Reset
REQ-030 While reset_n=0 at a clock edge, the block SHALL:
- go to IDLE;
- drive rd=0, addr=0, busy=0, done=0;
- clear slot_base_found, slot_base_address, slot_size and timeout_err;
- clear the index and timeout counters.
REQ-031 Reset asserted mid-search SHALL abandon the search without a done pulse, and a response arriving after reset SHALL be ignored.

Verification
REQ-032 Table id 0x0003 at entry 2, size 0x0001_2345, 1-cycle responder, slot_id=3 -> reads at 0xF800_2000, 0xF800_2008, 0xF800_2010, 0xF800_2014; done pulse; found=1; base=0xF800_2010; size=0x0001_2345.
REQ-033 slot_id=0x00FF, absent from all 32 entries -> 32 id reads, last at 0xF800_20F8; done pulse; found=0; timeout_err=0.
REQ-034 Responder silent on the first read -> done exactly 255 cycles after entering WAIT_ID; timeout_err=1; found=0.
REQ-035 Second start 3 cycles after the first, while busy -> ignored; exactly one done pulse; results match the first slot_id.
REQ-036 reset_n=0 for one cycle while in WAIT_SIZE, then late rd_data_valid -> no done pulse; all outputs 0; block stays IDLE.
REQ-037 Variable-latency responder of 1-10 cycles with a match at entry 31 -> base=0xF800_20F8; size captured from 0xF800_20FC; rd is one cycle per read.
